aes_inv_round: RTL and testbench

//  Iterative AES inverse-cipher datapath: decryption counterpart of the encrypt-side addroundkey/state path.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_inv_sbox.sv | 34 +++
 rtl/aes_inv_round.sv | 93 +++++++++
 tb/tb_aes_inv_round.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types and GF(2^8) helpers.
// Byte k of a state is bits [127-8k -: 8], k = 4*col + row.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    LAST
  } fsm_t;

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul9(byte_t b);
    byte_t b8;
    b8 = xtime(xtime(xtime(b)));
    return b8 ^ b;
  endfunction

  function automatic byte_t gmul11(byte_t b);
    byte_t b2, b8;
    b2 = xtime(b);
    b8 = xtime(xtime(b2));
    return b8 ^ b2 ^ b;
  endfunction

  function automatic byte_t gmul13(byte_t b);
    byte_t b4, b8;
    b4 = xtime(xtime(b));
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic byte_t gmul14(byte_t b);
    byte_t b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

  function automatic logic [31:0] inv_mix_col(logic [31:0] c);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {
      gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
      gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
      gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
      gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
    };
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][c-r].
  function automatic state_t inv_shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, pure combinational table lookup.
// Row n of the table below holds entries 16n..16n+15.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);

  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] pos;

  assign pos = 11'd2047 - {a, 3'b000};
  assign y   = TBL[pos -: 8];

endmodule

// File: rtl/aes_inv_round.sv
// Iterative AES inverse cipher: one inverse round per clock,
// round keys fetched in reverse order through key_idx.
module aes_inv_round
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] text_in,
  input  logic [127:0] round_key,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] text_out
);

  fsm_t   state, nstate;
  logic [3:0] cnt;
  state_t sa, sr, sb, fin, mixed;

  assign key_idx = cnt;
  assign sr      = inv_shift_rows(sa);

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_inv_sbox u_sb (
      .a(sr[127-8*i -: 8]),
      .y(sb[127-8*i -: 8])
    );
  end

  assign fin = sb ^ round_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] =
        inv_mix_col(fin[127-32*c -: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (ld) nstate = (NR == 1) ? LAST : ROUND;
      ROUND:   if (cnt == 4'd1) nstate = LAST;
      LAST:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // busy stays up through the done cycle and only falls
  // when the FSM sits idle without a new load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 4'(NR);
      sa       <= '0;
      text_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld) begin
            sa   <= text_in ^ round_key;
            cnt  <= 4'(NR - 1);
            busy <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ROUND: begin
          sa  <= mixed;
          cnt <= cnt - 4'd1;
        end
        LAST: begin
          text_out <= fin;
          done     <= 1'b1;
          cnt      <= 4'(NR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard bench for aes_inv_round (NR=10 and NR=14 instances).
// Reference: forward AES built from GF arithmetic; plaintext is expected.
module tb_aes_inv_round;

  localparam int NRA = 10;
  localparam int NRB = 14;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_a, rst_b, ld_a, ld_b;
  logic [127:0] tin_a, tin_b, rkey_a, rkey_b, tout_a, tout_b;
  logic [3:0]   kidx_a, kidx_b;
  logic         busy_a, busy_b, done_a, done_b;
  logic [0:14][127:0] rk_a, rk_b;

  assign rkey_a = rk_a[kidx_a];
  assign rkey_b = rk_b[kidx_b];

  aes_inv_round #(.NR(NRA)) u_a (
    .clk(clk), .rst(rst_a), .ld(ld_a), .text_in(tin_a),
    .round_key(rkey_a), .key_idx(kidx_a), .busy(busy_a),
    .done(done_a), .text_out(tout_a)
  );

  aes_inv_round #(.NR(NRB)) u_b (
    .clk(clk), .rst(rst_b), .ld(ld_b), .text_in(tin_b),
    .round_key(rkey_b), .key_idx(kidx_b), .busy(busy_b),
    .done(done_b), .text_out(tout_b)
  );

  int n_tot = 0;
  int n_pass = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] sbox [256];

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  // S-box from multiplicative inverse plus affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
                rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]],
            sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  function automatic logic [0:14][127:0] expand(logic [255:0] key,
                                                 int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:14][127:0] r;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++)
      r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [127:0] enc(logic [127:0] pt,
                                       logic [0:14][127:0] rks,
                                       int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] x;
    x = pt ^ rks[0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[x[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      if (rd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1];
          a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
      x ^= rks[rd];
    end
    return x;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitors: every done must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_a && done_a) begin
      if (q_a.size() == 0) begin
        n_tot++;
        $display("FAIL nr10_unexpected_done: got text_out %h, none expected",
                 tout_a);
      end else begin
        e = q_a.pop_front();
        chk("nr10_text_out", tout_a, e.pt);
        chk("nr10_latency", 128'(cyc), 128'(e.due));
        chk("nr10_busy_in_done", 128'(busy_a), 128'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_b && done_b) begin
      if (q_b.size() == 0) begin
        n_tot++;
        $display("FAIL nr14_unexpected_done: got text_out %h, none expected",
                 tout_b);
      end else begin
        e = q_b.pop_front();
        chk("nr14_text_out", tout_b, e.pt);
        chk("nr14_latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  task automatic issue_a(logic [127:0] ct, logic [127:0] pt,
                         bit accept);
    exp_t e;
    ld_a  = 1'b1;
    tin_a = ct;
    if (accept) begin
      e.pt  = pt;
      e.due = cyc + 1 + NRA;
      q_a.push_back(e);
    end
    @(negedge clk);
    ld_a  = 1'b0;
    tin_a = '0;
  endtask

  task automatic issue_b(logic [127:0] ct, logic [127:0] pt);
    exp_t e;
    ld_b  = 1'b1;
    tin_b = ct;
    e.pt  = pt;
    e.due = cyc + 1 + NRB;
    q_b.push_back(e);
    @(negedge clk);
    ld_b  = 1'b0;
    tin_b = '0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (q_a.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0) begin
      n_tot++;
      $display("FAIL nr10_timeout: got no done, %0d results pending",
               q_a.size());
      q_a.delete();
    end
    @(negedge clk);
    chk("nr10_busy_idle", 128'(busy_a), 128'd0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (q_b.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_b.size() != 0) begin
      n_tot++;
      $display("FAIL nr14_timeout: got no done, %0d results pending",
               q_b.size());
      q_b.delete();
    end
    @(negedge clk);
    chk("nr14_busy_idle", 128'(busy_b), 128'd0);
  endtask

  logic [255:0] key;
  logic [127:0] pt, ct;
  int           n;

  initial begin
    build_sbox();
    rst_a = 1'b0; rst_b = 1'b0;
    ld_a  = 1'b0; ld_b  = 1'b0;
    tin_a = '0;   tin_b = '0;
    rk_a  = '0;   rk_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_kidx_a", 128'(kidx_a), 128'd10);
    chk("rst_kidx_b", 128'(kidx_b), 128'd14);
    chk("rst_busy", 128'({busy_a, busy_b}), 128'd0);
    chk("rst_done", 128'({done_a, done_b}), 128'd0);
    chk("rst_tout_a", tout_a, 128'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // App B vector with key_idx walk 10..0
    rk_a = expand({KB, 128'h0}, 4);
    chk("kidx_ld_cycle", 128'(kidx_a), 128'd10);
    issue_a(CTB, PTB, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("kidx_seq", 128'(kidx_a), 128'(9 - k));
      chk("busy_run", 128'(busy_a), 128'd1);
      @(negedge clk);
    end
    drain_a();

    // C.1 with a stray ld mid-operation
    rk_a = expand({K1, 128'h0}, 4);
    issue_a(CT1, PT1, 1'b1);
    repeat (2) @(negedge clk);
    issue_a(CTB, PTB, 1'b0);
    drain_a();

    // back-to-back: ld in the done cycle
    issue_a(CT1, PT1, 1'b1);
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) begin
      n_tot++;
      $display("FAIL nr10_b2b_wait: got done=0 after %0d cycles", n);
    end
    issue_a(CT1, PT1, 1'b1);
    drain_a();

    // reset in the middle of an operation
    issue_a(CT1, PT1, 1'b1);
    repeat (4) @(negedge clk);
    rst_a = 1'b0;
    q_a.delete();
    #1;
    chk("midrst_done", 128'(done_a), 128'd0);
    chk("midrst_tout", tout_a, 128'd0);
    chk("midrst_kidx", 128'(kidx_a), 128'd10);
    chk("midrst_busy", 128'(busy_a), 128'd0);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (14) @(negedge clk);
    issue_a(CT1, PT1, 1'b1);
    drain_a();

    // random keys and plaintexts, AES-128
    for (int i = 0; i < 6; i++) begin
      key  = {rnd128(), 128'h0};
      pt   = rnd128();
      rk_a = expand(key, 4);
      ct   = enc(pt, rk_a, NRA);
      issue_a(ct, pt, 1'b1);
      drain_a();
    end

    // AES-256 instance: C.3 then random
    rk_b = expand(K3, 8);
    chk("nr14_kidx_idle", 128'(kidx_b), 128'd14);
    issue_b(CT3, PT1);
    drain_b();
    for (int i = 0; i < 3; i++) begin
      key  = {rnd128(), rnd128()};
      pt   = rnd128();
      rk_b = expand(key, 8);
      ct   = enc(pt, rk_b, NRB);
      issue_b(ct, pt);
      drain_b();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, %0d/%0d so far",
             n_pass, n_tot);
    $fatal(1);
  end

endmodule
